axi_ram_fill: RTL and testbench
===============================

AXI_RAM_FILL -- requirements
Module: axi_ram_fill

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, AXI byte address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, wstrb width.
REQ-004 SHALL have parameter ID_WIDTH, default 8, AXI ID width; awid driven constant 0.
REQ-005 SHALL have parameter LEN_WIDTH, default 8, awlen width.
REQ-006 SHALL have parameter BURST_LEN, default 16, max beats per burst; power of two, at most 2**LEN_WIDTH.
REQ-007 SHALL have parameter CNT_WIDTH, default 16, word-count width.
REQ-008 SHALL have clk (input, 1), rising-edge clock; and rst (input, 1), reset, synchronous, active-high.
REQ-009 SHALL have start (input, 1), command pulse, sampled only in IDLE.
REQ-010 SHALL have base_addr (input, ADDR_WIDTH), byte start address; low log2(STRB_WIDTH) bits ignored.
REQ-011 SHALL have word_count (input, CNT_WIDTH), number of words to write.
REQ-012 SHALL have pattern (input, DATA_WIDTH) and incr_mode (input, 1), data source select.
REQ-013 SHALL have busy, done, error outputs (1 each): running; one-cycle completion pulse; sticky write-error flag.
REQ-014 SHALL have an AXI4 master write port m_axi_aw* (id, addr, len, size, burst, valid, ready), m_axi_w* (data, strb, last, valid, ready), m_axi_b* (id, resp, valid, ready).

Function
REQ-015 SHALL use states IDLE, AW, W, B (plus RA, RD under REQ-031); IDLE->AW on start with word_count != 0.
REQ-016 SHALL, on start with word_count == 0, pulse done the next cycle, issue no transaction, and not set busy.
REQ-017 SHALL latch base_addr, word_count, pattern, incr_mode at start; later input changes are ignored until the next IDLE.
REQ-018 SHALL compute burst beats = min(remaining, BURST_LEN - (word_addr mod BURST_LEN)); bursts never cross a BURST_LEN-word boundary.
REQ-019 SHALL drive awlen = beats-1, awsize = log2(STRB_WIDTH), awburst = INCR, wstrb = all ones.
REQ-020 SHALL hold awvalid, awaddr, awlen stable from assertion until awready; AW->W on handshake.
REQ-021 SHALL assert wvalid after the AW handshake, advance on each wready, hold wdata stable while stalled, and assert wlast on the final beat only; W->B after the last beat.
REQ-022 SHALL set wdata = pattern if incr_mode=0, else pattern + word index (0-based from command start, modulo 2**DATA_WIDTH).
REQ-023 SHALL assert bready only in B; on B handshake, remaining != 0 goes to AW, otherwise IDLE with done pulsed that cycle.
REQ-024 SHALL keep at most one burst outstanding.
REQ-025 SHALL set error when bresp != 0, continue the fill, and clear error only on the next accepted start.
REQ-026 SHALL assert busy from the cycle after start until done is pulsed.
REQ-027 SHALL wrap the address modulo 2**ADDR_WIDTH without error.

Reset
REQ-028 SHALL, on rst, force IDLE and drive awvalid, wvalid, bready, busy, done, error (and arvalid, rready, mismatch) to 0, including mid-burst.
REQ-029 SHALL not pulse done for a command aborted by rst.

Configuration
REQ-030 SHALL build without AXI_RAM_FILL_VERIFY_EN as write-only: no AR/R ports, and done follows the last B.
REQ-031 SHALL, with AXI_RAM_FILL_VERIFY_EN defined, add m_axi_ar*/m_axi_r* ports and a mismatch output (sticky, cleared on start); after the last B, reread the region using the same burst split, compare each rdata against the expected value, set mismatch on any difference or rresp != 0, hold rready=1 in RD, and pulse done after the final rlast.

Structure
REQ-032 SHALL place state encoding, AXI burst/resp constants (INCR, OKAY) in shared package axi_ram_fill_pkg.
REQ-033 SHALL factor burst-length/address stepping into sub-module axi_ram_fill_burst_calc (combinational: addr, remaining -> beats).

Verification (against an axi_ram slave, DATA_WIDTH=32, BURST_LEN=16)
REQ-034 SHALL test base=0x0000, count=40, pattern=0xA5A5A5A5, incr=0 -> bursts of 16, 16, 8; all 40 words read 0xA5A5A5A5; one done pulse; error=0.
REQ-035 SHALL test base=0x0024 (word 9), count=10, incr=1, pattern=0x100 -> bursts of 7, 3; word 9=0x100 ... word 18=0x109.
REQ-036 SHALL test count=0 -> done exactly one cycle after start; no awvalid ever.
REQ-037 SHALL test random wready/awready/bvalid stalls (50%) -> wdata stable while stalled; memory contents identical to the unstalled run.
REQ-038 SHALL test a slave returning bresp=SLVERR on the 2nd burst -> error=1, fill completes, error cleared by the next start.
REQ-039 SHALL test rst asserted mid-W of the 1st burst -> all valids 0 the next cycle; no done; a new start then runs normally.

Source files
------------

// File: rtl/axi_ram_fill_pkg.sv
// axi_ram_fill_pkg: state encoding and AXI constants shared by the RAM fill engine
package axi_ram_fill_pkg;
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_RA, S_RD} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/axi_ram_fill_burst_calc.sv
// axi_ram_fill_burst_calc: burst length and address stepping that never crosses a BURST_LEN-word boundary
module axi_ram_fill_burst_calc #(
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = 4,
  parameter int CNT_WIDTH = 16,
  parameter int BURST_LEN = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [CNT_WIDTH-1:0]  remaining,
  output logic [CNT_WIDTH-1:0]  beats,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [CNT_WIDTH-1:0]  next_remaining
);
  localparam int SW = $clog2(STRB_WIDTH);
  localparam int BW = $clog2(BURST_LEN);
  logic [BW-1:0] offset;
  logic [CNT_WIDTH-1:0] room;
  always_comb begin
    offset = addr[SW +: BW];
    room = CNT_WIDTH'(BURST_LEN) - CNT_WIDTH'(offset);
    beats = remaining < room ? remaining : room;
    next_addr = addr + (ADDR_WIDTH'(beats) << SW);
    next_remaining = remaining - beats;
  end
endmodule

// File: rtl/axi_ram_fill.sv
// axi_ram_fill: AXI4 write-burst engine filling a RAM region with a constant or incrementing pattern
// AXI_RAM_FILL_VERIFY_EN adds a read-back pass comparing the region against the written data
module axi_ram_fill
  import axi_ram_fill_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH = 8,
  parameter int LEN_WIDTH = 8,
  parameter int BURST_LEN = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic                  incr_mode,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [LEN_WIDTH-1:0]  m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
`ifdef AXI_RAM_FILL_VERIFY_EN
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [LEN_WIDTH-1:0]  m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  mismatch,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, next_addr;
  logic [CNT_WIDTH-1:0] rem_q, rem_d, left_q, left_d, beats, next_rem;
  logic [DATA_WIDTH-1:0] pat_q, pat_d, idx_q, idx_d, exp_data;
  logic incr_q, incr_d, done_q, done_d, error_q, error_d;
`ifdef AXI_RAM_FILL_VERIFY_EN
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic mismatch_q, mismatch_d;
  logic unused_rid;
  assign unused_rid = ^m_axi_rid;
`endif
  logic unused_bid;
  assign unused_bid = ^m_axi_bid;
  axi_ram_fill_burst_calc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .STRB_WIDTH(STRB_WIDTH),
    .CNT_WIDTH(CNT_WIDTH),
    .BURST_LEN(BURST_LEN)
  ) u_calc (
    .addr(addr_q),
    .remaining(rem_q),
    .beats(beats),
    .next_addr(next_addr),
    .next_remaining(next_rem)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    left_d = left_q;
    pat_d = pat_q;
    incr_d = incr_q;
    idx_d = idx_q;
    done_d = 1'b0;
    error_d = error_q;
`ifdef AXI_RAM_FILL_VERIFY_EN
    base_d = base_q;
    cnt_d = cnt_q;
    mismatch_d = mismatch_q;
`endif
    exp_data = incr_q ? pat_q + idx_q : pat_q;
    case (state_q)
      S_IDLE: if (start) begin
        addr_d = base_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
        rem_d = word_count;
        pat_d = pattern;
        incr_d = incr_mode;
        idx_d = '0;
        error_d = 1'b0;
`ifdef AXI_RAM_FILL_VERIFY_EN
        base_d = base_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
        cnt_d = word_count;
        mismatch_d = 1'b0;
`endif
        state_d = word_count != '0 ? S_AW : S_IDLE;
        done_d = word_count == '0;
      end
      S_AW: if (m_axi_awready) begin
        addr_d = next_addr;
        rem_d = next_rem;
        left_d = beats;
        state_d = S_W;
      end
      S_W: if (m_axi_wready) begin
        idx_d = idx_q + 1'b1;
        left_d = left_q - 1'b1;
        state_d = left_q == CNT_WIDTH'(1) ? S_B : S_W;
      end
      S_B: if (m_axi_bvalid) begin
        error_d = error_q | (m_axi_bresp != AXI_RESP_OKAY);
`ifdef AXI_RAM_FILL_VERIFY_EN
        // rewind to the command start so the read pass reuses the write burst split
        addr_d = rem_q != '0 ? addr_q : base_q;
        rem_d = rem_q != '0 ? rem_q : cnt_q;
        idx_d = rem_q != '0 ? idx_q : '0;
        state_d = rem_q != '0 ? S_AW : S_RA;
`else
        state_d = rem_q != '0 ? S_AW : S_IDLE;
        done_d = rem_q == '0;
`endif
      end
`ifdef AXI_RAM_FILL_VERIFY_EN
      S_RA: if (m_axi_arready) begin
        addr_d = next_addr;
        rem_d = next_rem;
        state_d = S_RD;
      end
      S_RD: if (m_axi_rvalid) begin
        idx_d = idx_q + 1'b1;
        mismatch_d = mismatch_q | (m_axi_rdata != exp_data) | (m_axi_rresp != AXI_RESP_OKAY);
        state_d = !m_axi_rlast ? S_RD : rem_q != '0 ? S_RA : S_IDLE;
        done_d = m_axi_rlast && rem_q == '0;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? S_IDLE : state_d;
    done_q <= !rst && done_d;
    error_q <= !rst && error_d;
    addr_q <= addr_d;
    rem_q <= rem_d;
    left_q <= left_d;
    pat_q <= pat_d;
    incr_q <= incr_d;
    idx_q <= idx_d;
`ifdef AXI_RAM_FILL_VERIFY_EN
    base_q <= base_d;
    cnt_q <= cnt_d;
    mismatch_q <= !rst && mismatch_d;
`endif
  end
  assign m_axi_awid = '0;
  assign m_axi_awaddr = addr_q;
  assign m_axi_awlen = LEN_WIDTH'(beats - 1'b1);
  assign m_axi_awsize = 3'($clog2(STRB_WIDTH));
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = state_q == S_AW;
  assign m_axi_wdata = exp_data;
  assign m_axi_wstrb = '1;
  assign m_axi_wvalid = state_q == S_W;
  assign m_axi_wlast = m_axi_wvalid && left_q == CNT_WIDTH'(1);
  assign m_axi_bready = state_q == S_B;
`ifdef AXI_RAM_FILL_VERIFY_EN
  assign m_axi_arid = '0;
  assign m_axi_araddr = addr_q;
  assign m_axi_arlen = LEN_WIDTH'(beats - 1'b1);
  assign m_axi_arsize = 3'($clog2(STRB_WIDTH));
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arvalid = state_q == S_RA;
  assign m_axi_rready = state_q == S_RD;
  assign mismatch = mismatch_q;
`endif
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign error = error_q;
endmodule

// File: tb/tb_axi_ram_fill.sv
// tb_axi_ram_fill: directed bench for axi_ram_fill against a small AXI write-slave memory model
module tb_axi_ram_fill;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, incr_mode = 1'b0;
  logic [15:0] base_addr = '0, word_count = '0;
  logic [31:0] pattern = '0;
  logic [7:0] awid, awlen, bid;
  logic [15:0] awaddr;
  logic [2:0] awsize;
  logic [1:0] awburst, bresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, busy, done, error;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  axi_ram_fill dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .pattern(pattern), .incr_mode(incr_mode),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .busy(busy), .done(done), .error(error)
  );

  logic [31:0] mem [0:16383];
  logic [13:0] wptr;
  int burst_len [0:15];
  int aw_n, b_n, aw_cycles, viol, wleft;
  int err_burst = 0;
  logic stall_en = 1'b0, clr = 1'b0;
  logic b_pend, hold_w, hold_aw;
  logic [31:0] held_w;
  logic [15:0] held_addr;
  logic [7:0] held_len;
  assign bid = '0;

  // memory-backed slave plus protocol monitor; viol counts any AXI rule broken by the master
  always @(posedge clk) begin
    if (clr) begin
      foreach (mem[i]) mem[i] <= 32'hDEADBEEF;
      aw_n <= 0; b_n <= 0; aw_cycles <= 0; viol <= 0;
    end
    if (rst) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      b_pend <= 1'b0; hold_w <= 1'b0; hold_aw <= 1'b0;
    end else begin
      awready <= !stall_en || $urandom_range(0, 1) == 1;
      wready <= !stall_en || $urandom_range(0, 1) == 1;
      if (awvalid) aw_cycles <= aw_cycles + 1;
      if (awvalid && (awsize !== 3'd2 || awburst !== 2'b01 || awid !== 8'd0)) viol <= viol + 1;
      if (wvalid && wstrb !== 4'hF) viol <= viol + 1;
      if (awvalid && awready) begin
        wptr <= awaddr[15:2];
        wleft <= int'(awlen) + 1;
        if (aw_n < 16) burst_len[aw_n] <= int'(awlen) + 1;
        aw_n <= aw_n + 1;
      end
      if (wvalid && wready) begin
        mem[wptr] <= wdata;
        wptr <= wptr + 14'd1;
        wleft <= wleft - 1;
        if (wlast !== (wleft == 1)) viol <= viol + 1;
        if (wlast) b_pend <= 1'b1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      else if (b_pend && !bvalid && (!stall_en || $urandom_range(0, 1) == 1)) begin
        bvalid <= 1'b1;
        b_pend <= 1'b0;
        bresp <= (b_n + 1 == err_burst) ? 2'b10 : 2'b00;
        b_n <= b_n + 1;
      end
      hold_w <= wvalid && !wready;
      held_w <= wdata;
      hold_aw <= awvalid && !awready;
      held_addr <= awaddr;
      held_len <= awlen;
      if (hold_w && (!wvalid || wdata !== held_w)) viol <= viol + 1;
      if (hold_aw && (!awvalid || awaddr !== held_addr || awlen !== held_len)) viol <= viol + 1;
    end
  end

  task automatic clear_slave();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic kick(input logic [15:0] b, input logic [15:0] c, input logic [31:0] p, input logic i);
    base_addr = b; word_count = c; pattern = p; incr_mode = i; start = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = 16'h5554; word_count = 16'd3; pattern = 32'hFFFF0000; incr_mode = ~i;
  endtask

  task automatic wait_done(output int cyc, output int pulses);
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    pulses = done ? 1 : 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({awvalid, wvalid, bready, busy, done, error} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b expected 000000", {awvalid, wvalid, bready, busy, done, error});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill_const();
    int cyc, pulses;
    clear_slave();
    kick(16'h0000, 16'd40, 32'hA5A5A5A5, 1'b0);
    wait_done(cyc, pulses);
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL const_done_pulses: got %0d expected 1", pulses); end
    total++;
    if ({aw_n, burst_len[0], burst_len[1], burst_len[2]} !== {32'd3, 32'd16, 32'd16, 32'd8}) begin
      bad++;
      $display("FAIL const_bursts: got n=%0d %0d,%0d,%0d expected n=3 16,16,8", aw_n, burst_len[0], burst_len[1], burst_len[2]);
    end
    for (int i = 0; i < 40; i++) begin
      total++;
      if (mem[i] !== 32'hA5A5A5A5) begin bad++; $display("FAIL const_mem[%0d]: got %h expected a5a5a5a5", i, mem[i]); end
    end
    total++;
    if (mem[40] !== 32'hDEADBEEF) begin bad++; $display("FAIL const_mem_past_end: got %h expected deadbeef", mem[40]); end
    total++;
    if ({error, busy} !== 2'b00) begin bad++; $display("FAIL const_error_busy: got %b expected 00", {error, busy}); end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL const_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_fill_incr();
    int cyc, pulses;
    clear_slave();
    kick(16'h0024, 16'd10, 32'h00000100, 1'b1);
    wait_done(cyc, pulses);
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL incr_done_pulses: got %0d expected 1", pulses); end
    total++;
    if ({aw_n, burst_len[0], burst_len[1]} !== {32'd2, 32'd7, 32'd3}) begin
      bad++;
      $display("FAIL incr_bursts: got n=%0d %0d,%0d expected n=2 7,3", aw_n, burst_len[0], burst_len[1]);
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (mem[9 + i] !== 32'h100 + 32'(i)) begin bad++; $display("FAIL incr_mem[%0d]: got %h expected %h", 9 + i, mem[9 + i], 32'h100 + 32'(i)); end
    end
    total++;
    if ({mem[8], mem[19]} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL incr_mem_bounds: got %h %h expected deadbeef deadbeef", mem[8], mem[19]);
    end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL incr_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_zero_count();
    int cyc, pulses;
    clear_slave();
    kick(16'h0040, 16'd0, 32'h12345678, 1'b0);
    total++;
    if ({done, busy} !== 2'b10) begin bad++; $display("FAIL zero_done_busy: got %b expected 10", {done, busy}); end
    wait_done(cyc, pulses);
    total++;
    if (cyc !== 1 || pulses !== 1) begin bad++; $display("FAIL zero_timing: got cyc=%0d pulses=%0d expected cyc=1 pulses=1", cyc, pulses); end
    total++;
    if (aw_cycles !== 0) begin bad++; $display("FAIL zero_no_aw: got %0d awvalid cycles expected 0", aw_cycles); end
  endtask

  task automatic test_stalls();
    int cyc, pulses;
    clear_slave();
    stall_en = 1'b1;
    kick(16'h0000, 16'd40, 32'h00001000, 1'b1);
    wait_done(cyc, pulses);
    stall_en = 1'b0;
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL stall_done_pulses: got %0d expected 1", pulses); end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL stall_protocol: got %0d violations expected 0", viol); end
    total++;
    if ({aw_n, burst_len[0], burst_len[1], burst_len[2]} !== {32'd3, 32'd16, 32'd16, 32'd8}) begin
      bad++;
      $display("FAIL stall_bursts: got n=%0d %0d,%0d,%0d expected n=3 16,16,8", aw_n, burst_len[0], burst_len[1], burst_len[2]);
    end
    for (int i = 0; i < 40; i++) begin
      total++;
      if (mem[i] !== 32'h1000 + 32'(i)) begin bad++; $display("FAIL stall_mem[%0d]: got %h expected %h", i, mem[i], 32'h1000 + 32'(i)); end
    end
  endtask

  task automatic test_error();
    int cyc, pulses;
    clear_slave();
    err_burst = 2;
    kick(16'h0000, 16'd40, 32'h00000077, 1'b0);
    wait_done(cyc, pulses);
    err_burst = 0;
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL err_done_pulses: got %0d expected 1", pulses); end
    total++;
    if (error !== 1'b1) begin bad++; $display("FAIL err_flag_set: got %b expected 1", error); end
    total++;
    if ({aw_n, mem[39]} !== {32'd3, 32'h77}) begin bad++; $display("FAIL err_fill_complete: got n=%0d last=%h expected n=3 last=77", aw_n, mem[39]); end
    repeat (5) @(negedge clk);
    total++;
    if (error !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b expected 1", error); end
    kick(16'h0100, 16'd4, 32'h00000005, 1'b0);
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL err_cleared_on_start: got %b expected 0", error); end
    wait_done(cyc, pulses);
    total++;
    if ({error, pulses} !== {1'b0, 32'd1}) begin bad++; $display("FAIL err_next_cmd: got error=%b pulses=%0d expected error=0 pulses=1", error, pulses); end
  endtask

  task automatic test_reset_mid_burst();
    int cyc, pulses, n;
    clear_slave();
    kick(16'h0000, 16'd40, 32'h000000CC, 1'b0);
    n = 0;
    while (!wvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (wvalid !== 1'b1) begin bad++; $display("FAIL rstmid_reach_w: got wvalid=%b expected 1", wvalid); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({awvalid, wvalid, bready, busy, done, error} !== 6'b0) begin
      bad++;
      $display("FAIL rstmid_outputs: got %b expected 000000", {awvalid, wvalid, bready, busy, done, error});
    end
    rst = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) pulses++;
    end
    total++;
    if ({pulses, busy} !== {32'd0, 1'b0}) begin bad++; $display("FAIL rstmid_no_done: got pulses=%0d busy=%b expected 0 0", pulses, busy); end
    clear_slave();
    kick(16'h0024, 16'd10, 32'h00000100, 1'b1);
    wait_done(cyc, pulses);
    total++;
    if ({pulses, aw_n, burst_len[0], burst_len[1]} !== {32'd1, 32'd2, 32'd7, 32'd3}) begin
      bad++;
      $display("FAIL rstmid_restart: got pulses=%0d n=%0d %0d,%0d expected 1 2 7,3", pulses, aw_n, burst_len[0], burst_len[1]);
    end
    total++;
    if ({mem[9], mem[18]} !== {32'h100, 32'h109}) begin bad++; $display("FAIL rstmid_restart_mem: got %h %h expected 100 109", mem[9], mem[18]); end
  endtask

  task automatic test_wrap();
    int cyc, pulses;
    clear_slave();
    kick(16'hFFF8, 16'd4, 32'h0000AB00, 1'b1);
    wait_done(cyc, pulses);
    total++;
    if ({pulses, aw_n, burst_len[0], burst_len[1]} !== {32'd1, 32'd2, 32'd2, 32'd2}) begin
      bad++;
      $display("FAIL wrap_bursts: got pulses=%0d n=%0d %0d,%0d expected 1 2 2,2", pulses, aw_n, burst_len[0], burst_len[1]);
    end
    total++;
    if ({mem[16382], mem[16383], mem[0], mem[1]} !== {32'hAB00, 32'hAB01, 32'hAB02, 32'hAB03}) begin
      bad++;
      $display("FAIL wrap_mem: got %h %h %h %h expected ab00 ab01 ab02 ab03", mem[16382], mem[16383], mem[0], mem[1]);
    end
    total++;
    if ({error, viol} !== {1'b0, 32'd0}) begin bad++; $display("FAIL wrap_error_protocol: got error=%b viol=%0d expected 0 0", error, viol); end
  endtask

  initial begin
    test_reset();
    test_fill_const();
    test_fill_incr();
    test_zero_count();
    test_stalls();
    test_error();
    test_reset_mid_burst();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
